// File: rtl/pair_sum_pkg.sv
// Shared constants and helpers for the pipelined ring-pairwise adder.
package pair_sum_pkg;

   localparam int MAX_N_CH  = 16;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Bit offset of channel idx inside a flat vector of width-bit channels.
   function automatic int ch_off(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/pair_sum_stage.sv
// One valid/ready register stage. It can take a new beat in the same cycle
// that its held beat is taken downstream.
module pair_sum_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         free;

   always_comb begin
      free    = !valid_q | out_ready;
      valid_d = valid_q;
      data_d  = data_q;
      if (free) begin
         valid_d = in_valid;
         if (in_valid) data_d = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = free;
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/pair_sum_pipe.sv
// Two-stage pipelined ring-pairwise adder: sum i = ch i + ch (i+1) mod N_CH.
// Optional per-sum carry flags when PAIR_SUM_OVF_FLAG_EN is defined.
module pair_sum_pipe
   import pair_sum_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int N_CH     = 3,
   parameter int SAT_MODE = 0,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_CH*DATA_W-1:0] data_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_CH*DATA_W-1:0] sum_out,
   output logic [CNT_W-1:0]       txn_cnt
`ifdef PAIR_SUM_OVF_FLAG_EN
   ,
   output logic [N_CH-1:0]        ovf_flags
`endif
);

   localparam int PW = N_CH * DATA_W;
`ifdef PAIR_SUM_OVF_FLAG_EN
   localparam int S2_W = PW + N_CH;
`else
   localparam int S2_W = PW;
`endif

   if (N_CH < 2 || N_CH > MAX_N_CH || DATA_W < 1 ||
       (SAT_MODE != MODE_WRAP && SAT_MODE != MODE_SAT) || CNT_W < 1) begin : g_bad_param
      $error("pair_sum_pipe: illegal parameter set");
   end

   logic            s1_valid, s2_in_ready;
   logic [PW-1:0]   s1_data;
   logic [PW-1:0]   sum_w;
   logic [S2_W-1:0] s2_in, s2_q;

`ifdef PAIR_SUM_OVF_FLAG_EN
   logic [N_CH-1:0] ovf_w;
`endif

   pair_sum_stage #(.W(PW)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (data_in),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   // Carry is folded into the select so wrap mode still consumes it.
   for (genvar i = 0; i < N_CH; i++) begin : g_sum
      logic [DATA_W:0] raw;
      assign raw = {1'b0, s1_data[ch_off(i, DATA_W) +: DATA_W]}
                 + {1'b0, s1_data[ch_off((i + 1) % N_CH, DATA_W) +: DATA_W]};
      assign sum_w[ch_off(i, DATA_W) +: DATA_W] =
         (SAT_MODE == MODE_SAT && raw[DATA_W]) ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
`ifdef PAIR_SUM_OVF_FLAG_EN
      assign ovf_w[i] = raw[DATA_W];
`endif
   end

`ifdef PAIR_SUM_OVF_FLAG_EN
   assign s2_in = {ovf_w, sum_w};
`else
   assign s2_in = sum_w;
`endif

   pair_sum_stage #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

   assign sum_out = s2_q[PW-1:0];
`ifdef PAIR_SUM_OVF_FLAG_EN
   assign ovf_flags = s2_q[PW +: N_CH];
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_pair_sum_pipe.sv
// Self-checking bench for pair_sum_pipe: a wrap-mode instance and a
// saturating instance (CNT_W=4) share stimulus and one scoreboard.
module tb_pair_sum_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [23:0] data_in;

   logic        in_ready, out_valid, in_ready_s, out_valid_s;
   logic [23:0] sum_out, sum_out_s;
   logic [15:0] txn_cnt;
   logic [3:0]  txn_cnt_s;
`ifdef PAIR_SUM_OVF_FLAG_EN
   logic [2:0]  ovf, ovf_s;
`endif

   always #5 clk = ~clk;

   pair_sum_pipe #(.DATA_W(8), .N_CH(3), .SAT_MODE(0), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .txn_cnt(txn_cnt)
`ifdef PAIR_SUM_OVF_FLAG_EN
      , .ovf_flags(ovf)
`endif
   );

   pair_sum_pipe #(.DATA_W(8), .N_CH(3), .SAT_MODE(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .data_in(data_in), .out_valid(out_valid_s), .out_ready(out_ready),
      .sum_out(sum_out_s), .txn_cnt(txn_cnt_s)
`ifdef PAIR_SUM_OVF_FLAG_EN
      , .ovf_flags(ovf_s)
`endif
   );

   typedef struct {
      logic [23:0] wrap;
      logic [23:0] sat;
      logic [2:0]  flg;
   } exp_t;

   typedef struct {
      logic [23:0] d;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   exp_t cur_exp;
   exp_t mon_e;
   int   err = 0;
   int   chk = 0;
   int   exp_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      chk++;
      if (act !== req) begin
         err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [23:0] d);
      exp_t e;
      int   s;
      for (int i = 0; i < 3; i++) begin
         s = int'(d[i*8 +: 8]) + int'(d[((i + 1) % 3)*8 +: 8]);
         e.wrap[i*8 +: 8] = 8'(s % 256);
         e.sat[i*8 +: 8]  = (s > 255) ? 8'hFF : 8'(s);
         e.flg[i]         = (s > 255);
      end
      return e;
   endfunction

   function automatic vec_t mk(input int a, b, c, w0, w1, w2, s0, s1, s2, input logic [2:0] f);
      vec_t v;
      v.d      = {8'(c), 8'(b), 8'(a)};
      v.e.wrap = {8'(w2), 8'(w1), 8'(w0)};
      v.e.sat  = {8'(s2), 8'(s1), 8'(s0)};
      v.e.flg  = f;
      return v;
   endfunction

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) sb.push_back(cur_exp);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk++;
               err++;
               $display("FAIL unexpected_output: got %0h expected none", sum_out);
            end else begin
               mon_e = sb.pop_front();
               check("sb_sum_wrap", 32'(sum_out), 32'(mon_e.wrap));
               check("sb_sum_sat", 32'(sum_out_s), 32'(mon_e.sat));
               check("sb_sat_valid", 32'(out_valid_s), 32'd1);
`ifdef PAIR_SUM_OVF_FLAG_EN
               check("sb_ovf", 32'(ovf), 32'(mon_e.flg));
               check("sb_ovf_sat", 32'(ovf_s), 32'(mon_e.flg));
`endif
               check("sb_txn_cnt", 32'(txn_cnt), 32'(exp_cnt[15:0]));
               check("sb_txn_cnt_w4", 32'(txn_cnt_s), 32'(exp_cnt[3:0]));
               exp_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [23:0] d, input exp_t e);
      data_in  = d;
      cur_exp  = e;
      in_valid = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      out_ready = 1'b1;
      drive(v.d, v.e);
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("lat_t1_no_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_t2_valid", 32'(out_valid), 32'd1);
      check("tbl_sum_wrap", 32'(sum_out), 32'(v.e.wrap));
      check("tbl_sum_sat", 32'(sum_out_s), 32'(v.e.sat));
      tick();
      check("tbl_after_idle", 32'(out_valid), 32'd0);
   endtask

   vec_t        tbl[8];
   logic [23:0] bp[4];
   logic [23:0] rd;
   logic        hs;

   initial begin
      tbl[0] = mk(10, 20, 30,     30, 50, 40,     30, 50, 40,     3'b000);
      tbl[1] = mk(200, 100, 60,   44, 160, 4,     255, 160, 255,  3'b101);
      tbl[2] = mk(1, 2, 3,        3, 5, 4,        3, 5, 4,        3'b000);
      tbl[3] = mk(255, 1, 0,      0, 1, 255,      255, 1, 255,    3'b001);
      tbl[4] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        3'b000);
      tbl[5] = mk(128, 128, 128,  0, 0, 0,        255, 255, 255,  3'b111);
      tbl[6] = mk(255, 255, 255,  254, 254, 254,  255, 255, 255,  3'b111);
      tbl[7] = mk(127, 128, 0,    255, 128, 127,  255, 128, 127,  3'b000);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      cur_exp = model(24'd0);
      repeat (3) tick();
      check("rst_out_valid_low", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum_out", 32'(sum_out), 32'd0);
      check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      run_vec(tbl[0]);
      check("txn_cnt_after_first", 32'(txn_cnt), 32'd1);
      for (int k = 1; k < 8; k++) run_vec(tbl[k]);

      // Back-pressure: only two beats fit while downstream stalls.
      begin
         int k = 0, acc = 0, outs = 0, base;
         base = exp_cnt;
         for (int j = 0; j < 4; j++) bp[j] = 24'($urandom);
         out_ready = 1'b0;
         for (int c = 0; c < 6; c++) begin
            if (k < 4) drive(bp[k], model(bp[k]));
            #1;
            hs = in_valid && in_ready;
            tick();
            if (hs) begin acc++; k++; end
         end
         check("bp_accepted", 32'(acc), 32'd2);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_held_valid", 32'(out_valid), 32'd1);
         rd = model(bp[0]).wrap;
         check("bp_held_sum", 32'(sum_out), 32'(rd));
         out_ready = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (k < 4) drive(bp[k], model(bp[k]));
            else in_valid = 1'b0;
            #1;
            hs = in_valid && in_ready;
            if (out_valid) outs++;
            tick();
            if (hs) k++;
         end
         in_valid = 1'b0;
         check("bp_outs_back_to_back", 32'(outs), 32'd4);
         check("bp_all_sent", 32'(k), 32'd4);
         wait_drain(20);
         check("bp_txn_delta", 32'(txn_cnt), 32'(16'(base + 4)));
      end

      // Random handshakes against the reference model.
      begin
         int sent = 0, cyc = 0;
         in_valid = 1'b0;
         while (sent < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && $urandom_range(0, 9) < 7) begin
               rd = 24'($urandom);
               drive(rd, model(rd));
            end
            #1;
            hs = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) begin sent++; in_valid = 1'b0; end
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         check("rand_beats_sent", 32'(sent), 32'd10000);
         wait_drain(50);
      end

      // Reset with two beats in flight.
      out_ready = 1'b0;
      for (int j = 0; j < 2; j++) begin
         rd = 24'($urandom);
         drive(rd, model(rd));
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_valid_sat", 32'(out_valid_s), 32'd0);
      check("mid_rst_txn_cnt", 32'(txn_cnt), 32'd0);
      check("mid_rst_txn_cnt_w4", 32'(txn_cnt_s), 32'd0);
      check("mid_rst_sum_out", 32'(sum_out), 32'd0);
      sb.delete();
      exp_cnt = 0;
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      run_vec(tbl[2]);
      check("post_rst_txn_cnt", 32'(txn_cnt), 32'd1);

      // Fifteen more beats: 16 total, so the 4-bit counter wraps to zero.
      out_ready = 1'b1;
      for (int j = 0; j < 15; j++) begin
         rd = 24'($urandom);
         drive(rd, model(rd));
         tick();
      end
      in_valid = 1'b0;
      wait_drain(20);
      check("wrap_txn_cnt16", 32'(txn_cnt), 32'd16);
      check("wrap_txn_cnt_w4", 32'(txn_cnt_s), 32'd0);

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
